pulse_ctrl: RTL and testbench
=============================

# pulse_ctrl

Register front end and timing source for one APU pulse channel. It decodes CPU register writes (duty/volume, timer low, length/timer high) and runs the 11-bit period timer that produces the sequencer step tick. It also runs the length counter and drives the enable and duty-select inputs of the rectangle duty sequencer that produces the channel's 1-bit waveform.

## Interface
Parameters:
- `TIMER_W`, default 11: period timer width.
- `LEN_W`, default 8: length counter width.

Ports:
- `clk`  in  1  system clock.
- `iReset`  in  1  asynchronous, active-high reset.
- `iWr_en`  in  1  single-cycle register write strobe.
- `iAddr`  in  2  register select: 0 = ctrl, 1 = sweep (reserved), 2 = timer low, 3 = length/timer high.
- `iData`  in  8  write data.
- `iChannel_enable`  in  1  channel enable bit from the status register.
- `iHalf_frame`  in  1  single-cycle half-frame strobe from the frame sequencer.
- `oSeq_tick`  out  1  one-cycle pulse; advances the duty sequencer one step.
- `oDuty_cycle_type`  out  2  duty select to the sequencer.
- `oEnable`  out  1  gates the sequencer output.
- `oVolume`  out  4  constant volume / envelope period field.
- `oConst_vol`  out  1  constant-volume flag.
- `oLength_active`  out  1  length counter nonzero.

## Operation
- Reg 0 write: duty = `iData[7:6]`, halt = `iData[5]`, const_vol = `iData[4]`, volume = `iData[3:0]`.
- Reg 1 write: ignored. It is reserved for the sweep unit.
- Reg 2 write: period[7:0] = `iData`.
- Reg 3 write: period[10:8] = `iData[2:0]`.
  - If `iChannel_enable` is 1, length = `LENGTH_TABLE[iData[7:3]]`.
  - The timer counter reloads with the new full period on the next cycle.
- Timer: down-counter, decrements once per `clk`.
  - When it reaches 0, it reloads the period and asserts `oSeq_tick` for that cycle.
  - Tick interval is period+1 cycles.
  - Period changes via reg 2 take effect at the next natural reload.
- Length counter: on `iHalf_frame`, if halt = 0 and length ≠ 0, length decrements. It saturates at 0 and never wraps.
- `iChannel_enable` = 0 clears length to 0 every cycle it is low. While it is low, reg 3 does not load length.
- Mute rule: `oEnable` = `iChannel_enable` && (length ≠ 0) && (period ≥ 8). Period < 8 mutes the channel; the timer still ticks.
- Same-cycle conflicts:
  - Reg 3 load and `iHalf_frame`: the load wins and no decrement occurs.
  - Channel-disable clear and reg 3 load: the clear wins.
- State: ctrl regs, 11-bit period, 11-bit timer counter, 8-bit length counter. There is no FSM beyond the counters.

## Timing
- All outputs are registered. A write in cycle N is visible on outputs in cycle N+1.
- `oSeq_tick` is high exactly one cycle per timer expiry.
- Reset values:
  - period = 0, timer = 0, length = 0.
  - duty = 0, halt = 0, const_vol = 0, volume = 0.
  - `oSeq_tick` = 0, `oEnable` = 0, `oLength_active` = 0, `oDuty_cycle_type` = 0, `oVolume` = 0, `oConst_vol` = 0.
- Reset mid-count takes effect immediately (asynchronous). The first tick after reset release comes on the first clock edge, because timer = 0 reloads.
- `iHalf_frame` effect on length is visible one cycle after the strobe.

## Structure
- Shared package `apu_pkg`:
  - `LENGTH_TABLE[0:31]` = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - Register address constants.
  - `MIN_AUDIBLE_PERIOD` = 8.
- One natural sub-module, `apu_length_counter`: table lookup, load, halt, decrement and clear. It is reusable by the triangle and noise channels.

## Test plan
- Reset: assert `iReset` mid-operation → all outputs 0 immediately. After release, `oSeq_tick` pulses on the first edge.
- Period: write reg 2 = 0x03 and reg 3 = 0x08 (period 3, idx 1) with channel enabled → `oSeq_tick` every 4 cycles, length = 254, `oEnable` = 0 (period < 8). Write reg 2 = 0x08 → `oEnable` = 1 after the next reload.
- Length decrement: load idx 3 (length 2), pulse `iHalf_frame` three times → length 1, then 0, stays 0. `oLength_active` and `oEnable` drop after the second pulse.
- Halt: reg 0 = 0xA0 (duty 2, halt), load idx 0 (10), pulse `iHalf_frame` 5 times → length stays 10 and `oDuty_cycle_type` = 2.
- Disable: drop `iChannel_enable` → length 0 next cycle. A reg 3 write while disabled leaves length 0.
- Conflict: reg 3 write (idx 4 → 40) in the same cycle as `iHalf_frame` → length = 40, not 39.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared constants and types for the APU channel front ends
package apu_pkg;
  typedef enum logic [1:0] {REG_CTRL, REG_SWEEP, REG_TIMER_LO, REG_TIMER_HI} reg_addr_e;
  typedef struct packed {
    logic [1:0] duty;
    logic       halt;
    logic       const_vol;
    logic [3:0] volume;
  } ctrl_t;
  localparam int MIN_AUDIBLE_PERIOD = 8;
  localparam logic [7:0] LENGTH_TABLE [32] = '{
    8'd10, 8'd254, 8'd20, 8'd2, 8'd40, 8'd4, 8'd80, 8'd6,
    8'd160, 8'd8, 8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12, 8'd16, 8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };
endpackage

// File: rtl/apu_length_counter.sv
// apu_length_counter: table-loaded length counter with halt, half-frame decrement and disable clear
module apu_length_counter
  import apu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [4:0]       idx,
  input  logic             half_frame,
  input  logic             halt,
  output logic [LEN_W-1:0] length,
  output logic             active
);
  assign active = |length;
  always_ff @(posedge clk or posedge rst)
    if (rst) length <= '0;
    else if (!enable) length <= '0;
    else if (load) length <= LEN_W'(LENGTH_TABLE[idx]);
    else if (half_frame && !halt && active) length <= length - 1'b1;
endmodule

// File: rtl/pulse_ctrl.sv
// pulse_ctrl: pulse channel register decode, period timer and length gating for the duty sequencer
module pulse_ctrl
  import apu_pkg::*;
#(
  parameter int TIMER_W = 11,
  parameter int LEN_W   = 8
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iWr_en,
  input  logic [1:0] iAddr,
  input  logic [7:0] iData,
  input  logic       iChannel_enable,
  input  logic       iHalf_frame,
  output logic       oSeq_tick,
  output logic [1:0] oDuty_cycle_type,
  output logic       oEnable,
  output logic [3:0] oVolume,
  output logic       oConst_vol,
  output logic       oLength_active
);
  ctrl_t              ctrl;
  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] timer;
  logic [LEN_W-1:0]   length;
  logic               en_q;
  logic               wr_hi;
  assign wr_hi = iWr_en && iAddr == REG_TIMER_HI;
  always_ff @(posedge clk or posedge iReset)
    if (iReset) begin
      ctrl      <= '0;
      period    <= '0;
      timer     <= '0;
      oSeq_tick <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      if (iWr_en && iAddr == REG_CTRL) ctrl <= ctrl_t'(iData);
      if (iWr_en && iAddr == REG_TIMER_LO) period[7:0] <= iData;
      if (wr_hi) period[TIMER_W-1:8] <= iData[TIMER_W-9:0];
      // a high-byte write restarts the count with the full new period at once
      timer     <= wr_hi ? {iData[TIMER_W-9:0], period[7:0]} : timer == '0 ? period : timer - 1'b1;
      oSeq_tick <= timer == '0;
      en_q      <= iChannel_enable;
    end
  apu_length_counter #(.LEN_W(LEN_W)) u_len (
    .clk       (clk),
    .rst       (iReset),
    .enable    (iChannel_enable),
    .load      (wr_hi),
    .idx       (iData[7:3]),
    .half_frame(iHalf_frame),
    .halt      (ctrl.halt),
    .length    (length),
    .active    (oLength_active)
  );
  assign oDuty_cycle_type = ctrl.duty;
  assign oVolume          = ctrl.volume;
  assign oConst_vol       = ctrl.const_vol;
  assign oEnable          = en_q && oLength_active && period >= TIMER_W'(MIN_AUDIBLE_PERIOD);
endmodule

// File: tb/tb_pulse_ctrl.sv
// tb_pulse_ctrl: directed and randomized checks of pulse_ctrl against a cycle-level behavioural model
module tb_pulse_ctrl;
  logic       clk = 0, iReset = 1, iWr_en = 0, iChannel_enable = 0, iHalf_frame = 0;
  logic [1:0] iAddr = 0;
  logic [7:0] iData = 0;
  logic       oSeq_tick, oEnable, oConst_vol, oLength_active;
  logic [1:0] oDuty_cycle_type;
  logic [3:0] oVolume;

  pulse_ctrl dut (
    .clk(clk), .iReset(iReset), .iWr_en(iWr_en), .iAddr(iAddr), .iData(iData),
    .iChannel_enable(iChannel_enable), .iHalf_frame(iHalf_frame), .oSeq_tick(oSeq_tick),
    .oDuty_cycle_type(oDuty_cycle_type), .oEnable(oEnable), .oVolume(oVolume),
    .oConst_vol(oConst_vol), .oLength_active(oLength_active)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit go = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  int tbl [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                   12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  int m_duty, m_halt, m_cv, m_vol, m_per, m_len, m_en, m_tick;
  longint e, exp_e;

  // model: absolute edge index of the next timer expiry, plus plain register shadows
  initial forever begin
    @(posedge clk or posedge iReset);
    if (iReset) begin
      m_duty = 0; m_halt = 0; m_cv = 0; m_vol = 0; m_per = 0; m_len = 0; m_en = 0; m_tick = 0;
      e = 0; exp_e = 1;
    end else begin
      int np;
      bit hi;
      e++;
      hi = iWr_en && iAddr == 3;
      np = (int'(iData[2:0]) << 8) | (m_per & 255);
      m_tick = (e == exp_e) ? 1 : 0;
      if (hi) exp_e = e + np + 1;
      else if (m_tick == 1) exp_e = e + m_per + 1;
      if (!iChannel_enable) m_len = 0;
      else if (hi) m_len = tbl[iData[7:3]];
      else if (iHalf_frame && m_halt == 0 && m_len > 0) m_len--;
      if (iWr_en && iAddr == 0) begin
        m_duty = iData[7:6]; m_halt = iData[5]; m_cv = iData[4]; m_vol = iData[3:0];
      end
      if (iWr_en && iAddr == 2) m_per = (m_per & 'h700) | int'(iData);
      if (hi) m_per = np;
      m_en = iChannel_enable;
    end
  end

  initial forever begin
    @(negedge clk);
    if (go && !iReset) begin
      chk("tick", oSeq_tick, m_tick);
      chk("duty", oDuty_cycle_type, m_duty);
      chk("volume", oVolume, m_vol);
      chk("const_vol", oConst_vol, m_cv);
      chk("length_active", oLength_active, m_len != 0);
      chk("enable", oEnable, (m_en != 0 && m_len != 0 && m_per >= 8) ? 1 : 0);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic hf);
    iWr_en = 1; iAddr = a; iData = d; iHalf_frame = hf;
    @(negedge clk);
    iWr_en = 0; iHalf_frame = 0;
  endtask

  task automatic pulse();
    iHalf_frame = 1;
    @(negedge clk);
    iHalf_frame = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_tick"}, oSeq_tick, 0);
    chk({tag, "_duty"}, oDuty_cycle_type, 0);
    chk({tag, "_enable"}, oEnable, 0);
    chk({tag, "_volume"}, oVolume, 0);
    chk({tag, "_const_vol"}, oConst_vol, 0);
    chk({tag, "_length_active"}, oLength_active, 0);
  endtask

  initial begin
    int k;
    @(negedge clk);
    chk_zero("reset");
    go = 1;
    iReset = 0;
    @(negedge clk);
    chk("first_tick", oSeq_tick, 1);
    iChannel_enable = 1;
    wr(2, 8'h03, 0);
    wr(3, 8'h08, 0);
    k = 0;
    while (!oSeq_tick && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("tick_seen", oSeq_tick, 1);
    repeat (3) begin
      @(negedge clk);
      chk("p3_gap", oSeq_tick, 0);
    end
    @(negedge clk);
    chk("p3_tick", oSeq_tick, 1);
    chk("p3_muted", oEnable, 0);
    chk("p3_len", oLength_active, 1);
    wr(2, 8'h08, 0);
    repeat (4) @(negedge clk);
    chk("p8_audible", oEnable, 1);
    wr(3, 8'h18, 0);
    pulse();
    chk("len2_1", oLength_active, 1);
    pulse();
    chk("len2_0", oLength_active, 0);
    chk("len2_en", oEnable, 0);
    pulse();
    chk("len2_sat", oLength_active, 0);
    wr(0, 8'hA0, 0);
    wr(3, 8'h00, 0);
    repeat (5) pulse();
    chk("halt_len", oLength_active, 1);
    chk("halt_duty", oDuty_cycle_type, 2);
    wr(0, 8'h00, 0);
    repeat (9) pulse();
    chk("len10_9", oLength_active, 1);
    pulse();
    chk("len10_10", oLength_active, 0);
    wr(3, 8'h00, 0);
    iChannel_enable = 0;
    @(negedge clk);
    chk("disable_clear", oLength_active, 0);
    wr(3, 8'h08, 0);
    chk("disable_noload", oLength_active, 0);
    iChannel_enable = 1;
    @(negedge clk);
    chk("reenable", oLength_active, 0);
    wr(3, 8'h20, 1);
    repeat (39) pulse();
    chk("conflict_39", oLength_active, 1);
    pulse();
    chk("conflict_40", oLength_active, 0);
    wr(0, 8'hDF, 0);
    wr(3, 8'h08, 0);
    chk("pre_rst_vol", oVolume, 15);
    chk("pre_rst_en", oEnable, 1);
    @(posedge clk);
    #2 iReset = 1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    iReset = 0;
    @(negedge clk);
    chk("post_rst_tick", oSeq_tick, 1);
    repeat (3000) begin
      iWr_en = $urandom_range(0, 3) == 0;
      iAddr = 2'($urandom);
      iData = 8'($urandom);
      if ($urandom_range(0, 1) == 1) iData[2:0] = 3'd0;
      iHalf_frame = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 99) == 0) iChannel_enable = ~iChannel_enable;
      iReset = $urandom_range(0, 499) == 0;
      @(negedge clk);
    end
    iReset = 0; iWr_en = 0; iHalf_frame = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
